// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Issues start pulses, tracks tx_busy per frame and gates frame-format updates.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [4:0]                  cfg_in,
  output logic [4:0]                  cfg_out,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [4:0] CFG_RST = 5'b01011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDW-1:0]    r_ptr;
  logic [CW-1:0]     r_cnt;
  logic              w_found;
  logic [IDW-1:0]    w_gnt;
  logic [DATA_W-1:0] w_gdata;
  logic              w_to;

  // Scan from the index after the last winner, wrapping around.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    w_gdata = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = idx;
        w_gdata = DATA_W'(req_data >> (int'(idx) * DATA_W));
      end
    end
  end

  assign w_to = (r_cnt == CW'(BUSY_TIMEOUT - 1)) && !tx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!tx_busy && w_found) w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)   w_next = S_WAIT_DONE;
        else if (w_to) w_next = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      cfg_out     <= CFG_RST;
      r_ptr       <= IDW'(NUM_REQ - 1);
      r_cnt       <= '0;
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!tx_busy) begin
            cfg_out <= cfg_in;
            if (w_found) begin
              req_ready[w_gnt] <= 1'b1;
              tx_start         <= 1'b1;
              tx_data          <= w_gdata;
              grant_id         <= w_gnt;
              r_ptr            <= w_gnt;
              active           <= 1'b1;
              r_cnt            <= '0;
            end
          end
        end
        S_WAIT_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          // Set after the clear so a coincident timeout wins.
          if (w_to) begin
            timeout_err <= 1'b1;
            active      <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
